cpu_ram_arbiter: RTL

- Shares the single-port 256x16 system RAM (synchronous read, 1-cycle latency) between two requesters.
- Requester A: CPU fetch/data port.
- Requester B: program loader / debug port, which writes instruction images into RAM while the CPU runs or is held off.
- Sits between the CPU and the RAM in the system top level; does weighted round-robin arbitration and steers read responses back to the requester that issued them.

---
 rtl/cpu_ram_arbiter_if.sv | 16 +
 rtl/cpu_ram_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/cpu_ram_arbiter_if.sv
// Requester-side RAM access port: request/write bus out, grant and read response back.
interface cpu_ram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/cpu_ram_arbiter.sv
// cpu_ram_arbiter: weighted round-robin sharing of a single-port synchronous RAM
// between the CPU (port a) and the program loader / debug port (port b).
// Optional macro ARB_LOCK_EN adds B_LOCK, which lets the loader override arbitration.
module cpu_ram_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int BURST_MAX = 4
) (
  input  logic          CLK,
  input  logic          CLR,
  cpu_ram_arbiter_if.slave a,
  cpu_ram_arbiter_if.slave b,
`ifdef ARB_LOCK_EN
  input  logic          B_LOCK,
`endif
  output logic          RAM_EN,
  output logic          RAM_WE,
  output logic [AW-1:0] RAM_ADDR,
  output logic [DW-1:0] RAM_WDATA,
  input  logic [DW-1:0] RAM_RDATA,
  output logic [7:0]    CONTEND_CNT
);

  typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} sel_e;

  localparam logic [3:0] BM = 4'(BURST_MAX);

  sel_e       last;
  logic [3:0] run;
  logic       rv_a, rv_b;
  logic       contested, lock, flip, a_gnt, b_gnt;

`ifdef ARB_LOCK_EN
  assign lock = B_LOCK;
`else
  assign lock = 1'b0;
`endif

  assign contested = a.req & b.req;

  // RUN=0 marks "no contested run in progress", so a fresh contest goes to the
  // requester that did not win last; this is what makes A win the first contest
  // after reset (LAST=B) and keeps every run exactly BURST_MAX long.
  assign flip = (run == 4'd0) || (run >= BM);

  // Grant decision: combinational from requests and arbiter state, suppressed in reset.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!CLR) begin
      if (contested) begin
        if (lock)
          b_gnt = 1'b1;
        else if (flip)
          b_gnt = (last == SEL_A);
        else
          b_gnt = (last == SEL_B);
        a_gnt = ~b_gnt;
      end else begin
        a_gnt = a.req;
        b_gnt = b.req;
      end
    end
  end

  // RAM request mux: winner's bus in the grant cycle, all zero when idle.
  always_comb begin
    RAM_EN    = a_gnt | b_gnt;
    RAM_WE    = 1'b0;
    RAM_ADDR  = '0;
    RAM_WDATA = '0;
    if (a_gnt) begin
      RAM_WE    = a.we;
      RAM_ADDR  = a.addr;
      RAM_WDATA = a.wdata;
    end else if (b_gnt) begin
      RAM_WE    = b.we;
      RAM_ADDR  = b.addr;
      RAM_WDATA = b.wdata;
    end
  end

  // Arbiter state, contention counter and read-response steering.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      last        <= SEL_B;
      run         <= '0;
      rv_a        <= 1'b0;
      rv_b        <= 1'b0;
      CONTEND_CNT <= '0;
    end else begin
      rv_a <= a_gnt & ~a.we;
      rv_b <= b_gnt & ~b.we;
      if (contested) begin
        if (CONTEND_CNT != 8'hFF)
          CONTEND_CNT <= CONTEND_CNT + 8'd1;
        if (lock) begin
          last <= SEL_B;
          run  <= '0;
        end else if (flip) begin
          last <= (last == SEL_A) ? SEL_B : SEL_A;
          run  <= 4'd1;
        end else begin
          run  <= run + 4'd1;
        end
      end else if (a_gnt) begin
        last <= SEL_A;
        run  <= '0;
      end else if (b_gnt) begin
        last <= SEL_B;
        run  <= '0;
      end
    end
  end

  // A response whose cycle coincides with CLR is dropped, so RVALID is also
  // masked while CLR is high rather than only cleared at the next edge.
  assign a.gnt    = a_gnt;
  assign b.gnt    = b_gnt;
  assign a.rvalid = rv_a & ~CLR;
  assign b.rvalid = rv_b & ~CLR;
  assign a.rdata  = RAM_RDATA;
  assign b.rdata  = RAM_RDATA;

endmodule
